hazard_stall_unit: RTL and testbench

- Stall and flush controller for the 5-stage MIPS-32 pipeline.
- Complements the bypass path: it handles the hazards that forwarding cannot resolve. These are load-use, branch-in-ID operand dependencies, and multi-cycle mul/div occupancy of EX.
- Drives the PC, IF/ID, ID/EX and EX/MEM write/bubble controls.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_stall_unit_if.sv | 39 +++
 rtl/hazard_stall_unit.sv | 115 +++++++++++
 tb/tb_hazard_stall_unit.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side signals exchanged with the hazard/stall controller.
// The master modport is the pipeline; the slave modport is the controller.
interface hazard_stall_unit_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       Rs_ID;
    logic [4:0]       Rt_ID;
    logic             UsesRt_ID;
    logic             Branch_ID;
    logic             BranchTaken;
    logic [4:0]       Rd_EX;
    logic             RegWrite_EX;
    logic             MemRead_EX;
    logic             MulDiv_EX;
    logic [4:0]       Rd_MEM;
    logic             MemRead_MEM;
    logic             PCWrite;
    logic             IF_ID_Write;
    logic             IF_ID_Flush;
    logic             ID_EX_Bubble;
    logic             EX_Hold;
    logic             EX_MEM_Bubble;
    logic             Busy;
    logic [CNT_W-1:0] StallCycles;

    modport master (
        output Rs_ID, Rt_ID, UsesRt_ID, Branch_ID, BranchTaken,
               Rd_EX, RegWrite_EX, MemRead_EX, MulDiv_EX, Rd_MEM, MemRead_MEM,
        input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_Hold,
               EX_MEM_Bubble, Busy, StallCycles
    );

    modport slave (
        input  Rs_ID, Rt_ID, UsesRt_ID, Branch_ID, BranchTaken,
               Rd_EX, RegWrite_EX, MemRead_EX, MulDiv_EX, Rd_MEM, MemRead_MEM,
        output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_Hold,
               EX_MEM_Bubble, Busy, StallCycles
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage MIPS-32 pipeline: load-use and
// branch-in-ID interlocks, mul/div EX occupancy, and a stall-cycle counter.
module hazard_stall_unit #(
    parameter int MULDIV_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    hazard_stall_unit_if.slave hz
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [5:0]       r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_match_ex, w_match_mem;
    logic             w_hold, w_stall;
    logic             w_pcwrite, w_ifid_write, w_ifid_flush;
    logic             w_idex_bubble, w_ex_hold, w_exmem_bubble;

    // Register 0 is hard-wired, so a zero destination never creates a dependency.
    always_comb begin
        w_match_ex  = (hz.Rd_EX != 5'd0) &&
                      ((hz.Rs_ID == hz.Rd_EX) || (hz.UsesRt_ID && (hz.Rt_ID == hz.Rd_EX)));
        w_match_mem = (hz.Rd_MEM != 5'd0) &&
                      ((hz.Rs_ID == hz.Rd_MEM) || (hz.UsesRt_ID && (hz.Rt_ID == hz.Rd_MEM)));
        w_stall     = (hz.MemRead_EX && w_match_ex) ||
                      (hz.Branch_ID && hz.RegWrite_EX && w_match_ex) ||
                      (hz.Branch_ID && hz.MemRead_MEM && w_match_mem);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The IDLE detection cycle is itself a hold cycle, so BUSY covers MULDIV_CYCLES-1.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hold      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (hz.MulDiv_EX) begin
                    w_hold      = 1'b1;
                    w_cnt_nxt   = 6'(MULDIV_CYCLES - 2);
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                w_hold = 1'b1;
                if (r_cnt == 6'd0) begin
                    w_state_nxt = RELEASE;
                end else begin
                    w_cnt_nxt = r_cnt - 6'd1;
                end
            end
            RELEASE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        w_pcwrite      = 1'b1;
        w_ifid_write   = 1'b1;
        w_ifid_flush   = 1'b0;
        w_idex_bubble  = 1'b0;
        w_ex_hold      = 1'b0;
        w_exmem_bubble = 1'b0;
        if (!Reset) begin
            if (w_hold) begin
                w_pcwrite      = 1'b0;
                w_ifid_write   = 1'b0;
                w_ex_hold      = 1'b1;
                w_exmem_bubble = 1'b1;
            end else if (w_stall) begin
                w_pcwrite     = 1'b0;
                w_ifid_write  = 1'b0;
                w_idex_bubble = 1'b1;
            end else if (hz.BranchTaken) begin
                w_ifid_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_stall_cnt <= '0;
        end else if (!w_pcwrite && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign hz.PCWrite       = w_pcwrite;
    assign hz.IF_ID_Write   = w_ifid_write;
    assign hz.IF_ID_Flush   = w_ifid_flush;
    assign hz.ID_EX_Bubble  = w_idex_bubble;
    assign hz.EX_Hold       = w_ex_hold;
    assign hz.EX_MEM_Bubble = w_exmem_bubble;
    assign hz.Busy          = (r_state != IDLE);
    assign hz.StallCycles   = r_stall_cnt;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: two instances (default sizing and
// a short mul/div with a 2-bit counter) share stimulus and a reference model.
module tb_hazard_stall_unit;
    localparam int M0 = 4;
    localparam int W0 = 16;
    localparam int M1 = 2;
    localparam int W1 = 2;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    logic [4:0] rs, rt, rdex, rdmem;
    logic       urt, br, bt, rwex, mrex, md, mrmem;

    hazard_stall_unit_if #(.CNT_W(W0)) hz0 ();
    hazard_stall_unit_if #(.CNT_W(W1)) hz1 ();

    hazard_stall_unit #(.MULDIV_CYCLES(M0), .CNT_W(W0)) u_dut (
        .Clk(Clk), .Reset(Reset), .hz(hz0)
    );
    hazard_stall_unit #(.MULDIV_CYCLES(M1), .CNT_W(W1)) u_sat (
        .Clk(Clk), .Reset(Reset), .hz(hz1)
    );

    always_comb begin
        hz0.Rs_ID = rs;   hz0.Rt_ID = rt;     hz0.UsesRt_ID = urt;
        hz0.Branch_ID = br; hz0.BranchTaken = bt; hz0.Rd_EX = rdex;
        hz0.RegWrite_EX = rwex; hz0.MemRead_EX = mrex; hz0.MulDiv_EX = md;
        hz0.Rd_MEM = rdmem; hz0.MemRead_MEM = mrmem;
        hz1.Rs_ID = rs;   hz1.Rt_ID = rt;     hz1.UsesRt_ID = urt;
        hz1.Branch_ID = br; hz1.BranchTaken = bt; hz1.Rd_EX = rdex;
        hz1.RegWrite_EX = rwex; hz1.MemRead_EX = mrex; hz1.MulDiv_EX = md;
        hz1.Rd_MEM = rdmem; hz1.MemRead_MEM = mrmem;
    end

    logic [6:0] a_ctl0, a_ctl1;
    assign a_ctl0 = {hz0.PCWrite, hz0.IF_ID_Write, hz0.IF_ID_Flush, hz0.ID_EX_Bubble,
                     hz0.EX_Hold, hz0.EX_MEM_Bubble, hz0.Busy};
    assign a_ctl1 = {hz1.PCWrite, hz1.IF_ID_Write, hz1.IF_ID_Flush, hz1.ID_EX_Bubble,
                     hz1.EX_Hold, hz1.EX_MEM_Bubble, hz1.Busy};

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: age = position of the current mul/div within its EX
    // residency (1..M hold cycles, M+1 release), 0 when EX is free.
    int         age[2];
    int         eff[2];
    int         cnt[2];
    int         mlen[2];
    int         cmax[2];
    logic [6:0] exp_ctl[2];
    string      nm[7];

    task automatic check(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic bit dep(input logic [4:0] rd);
        return (rd != 5'd0) && ((rs == rd) || (urt && (rt == rd)));
    endfunction

    task automatic model_eval();
        for (int k = 0; k < 2; k++) begin
            if (Reset) begin
                age[k] = 0;
                cnt[k] = 0;
                eff[k] = 0;
                exp_ctl[k] = 7'b1100000;
            end else begin
                bit hold, stall, pcw, flush;
                eff[k] = (age[k] == 0 && md) ? 1 : age[k];
                hold   = (eff[k] >= 1) && (eff[k] <= mlen[k]);
                stall  = !hold && ((mrex && dep(rdex)) || (br && rwex && dep(rdex)) ||
                                   (br && mrmem && dep(rdmem)));
                pcw    = !(hold || stall);
                flush  = pcw && bt;
                exp_ctl[k] = {pcw, pcw, flush, stall, hold, hold, (age[k] != 0)};
            end
        end
    endtask

    task automatic model_clock();
        for (int k = 0; k < 2; k++) begin
            if (Reset) begin
                age[k] = 0;
                cnt[k] = 0;
            end else begin
                if (!exp_ctl[k][6]) cnt[k] = (cnt[k] < cmax[k]) ? cnt[k] + 1 : cmax[k];
                age[k] = (eff[k] >= 1 && eff[k] <= mlen[k]) ? eff[k] + 1 : 0;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        for (int k = 0; k < 2; k++) begin
            logic [6:0] act;
            int         acnt;
            act  = (k == 0) ? a_ctl0 : a_ctl1;
            acnt = (k == 0) ? int'(hz0.StallCycles) : int'(hz1.StallCycles);
            for (int j = 0; j < 7; j++) begin
                check($sformatf("%s %s[u%0d]", tag, nm[j], k), int'(act[6-j]), int'(exp_ctl[k][6-j]));
            end
            check($sformatf("%s StallCycles[u%0d]", tag, k), acnt, cnt[k]);
        end
    endtask

    task automatic settle(input string tag);
        #1;
        model_eval();
        compare_all(tag);
    endtask

    task automatic tick();
        @(posedge Clk);
        model_clock();
        #1;
    endtask

    task automatic clear_inputs();
        rs = '0; rt = '0; rdex = '0; rdmem = '0;
        urt = 1'b0; br = 1'b0; bt = 1'b0; rwex = 1'b0; mrex = 1'b0; md = 1'b0; mrmem = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        clear_inputs();
        settle("reset");
        tick();
        settle("reset");
        tick();
        Reset = 1'b0;
    endtask

    typedef struct {
        logic [4:0] rs, rt;
        logic       urt, br, bt;
        logic [4:0] rdex;
        logic       rwex, mrex;
        logic [4:0] rdmem;
        logic       mrmem;
        logic       pcw, flush, bub;
    } vec_t;

    vec_t vecs[13];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nm = '{"PCWrite", "IF_ID_Write", "IF_ID_Flush", "ID_EX_Bubble",
               "EX_Hold", "EX_MEM_Bubble", "Busy"};
        mlen = '{M0, M1};
        cmax = '{(1 << W0) - 1, (1 << W1) - 1};
        age = '{0, 0};
        cnt = '{0, 0};
        //          rs     rt    urt  br   bt   rdex  rwex mrex rdmem mrmem pcw flush bub
        vecs[0]  = '{5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{5'd8, 5'd2, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{5'd1, 5'd9, 1'b1, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{5'd1, 5'd9, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{5'd8, 5'd2, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{5'd8, 5'd2, 1'b1, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{5'd1, 5'd6, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{5'd6, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{5'd1, 5'd3, 1'b1, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{5'd4, 5'd2, 1'b0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{5'd1, 5'd7, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0};

        clear_inputs();
        do_reset();

        // Single-cycle hazard table
        foreach (vecs[i]) begin
            rs = vecs[i].rs; rt = vecs[i].rt; urt = vecs[i].urt; br = vecs[i].br;
            bt = vecs[i].bt; rdex = vecs[i].rdex; rwex = vecs[i].rwex; mrex = vecs[i].mrex;
            rdmem = vecs[i].rdmem; mrmem = vecs[i].mrmem; md = 1'b0;
            settle($sformatf("vec%0d", i));
            check($sformatf("vec%0d pcw", i), int'(hz0.PCWrite), int'(vecs[i].pcw));
            check($sformatf("vec%0d ifid_wr", i), int'(hz0.IF_ID_Write), int'(vecs[i].pcw));
            check($sformatf("vec%0d flush", i), int'(hz0.IF_ID_Flush), int'(vecs[i].flush));
            check($sformatf("vec%0d bubble", i), int'(hz0.ID_EX_Bubble), int'(vecs[i].bub));
            check($sformatf("vec%0d hold", i), int'(hz0.EX_Hold), 0);
            tick();
        end

        // Load-use then pass-through
        do_reset();
        mrex = 1'b1; rdex = 5'd8; rs = 5'd8; rwex = 1'b1;
        settle("loaduse");
        check("loaduse pcw", int'(hz0.PCWrite), 0);
        check("loaduse bubble", int'(hz0.ID_EX_Bubble), 1);
        tick();
        mrex = 1'b0;
        settle("loaduse_after");
        check("loaduse_after pcw", int'(hz0.PCWrite), 1);
        check("loaduse_after bubble", int'(hz0.ID_EX_Bubble), 0);
        tick();
        check("loaduse count", int'(hz0.StallCycles), 1);

        // Branch dependent on a load: two stall cycles, then taken flush
        do_reset();
        br = 1'b1; rs = 5'd5; mrex = 1'b1; rwex = 1'b1; rdex = 5'd5;
        settle("brload1");
        check("brload1 pcw", int'(hz0.PCWrite), 0);
        tick();
        mrex = 1'b0; rwex = 1'b0; rdex = 5'd0; mrmem = 1'b1; rdmem = 5'd5;
        settle("brload2");
        check("brload2 bubble", int'(hz0.ID_EX_Bubble), 1);
        tick();
        mrmem = 1'b0; rdmem = 5'd0; bt = 1'b1;
        settle("brload3");
        check("brload3 flush", int'(hz0.IF_ID_Flush), 1);
        check("brload3 pcw", int'(hz0.PCWrite), 1);
        tick();
        check("brload count", int'(hz0.StallCycles), 2);

        // Mul/div occupancy with priority over ID hazards and BranchTaken
        do_reset();
        md = 1'b1; mrex = 1'b1; rdex = 5'd3; rs = 5'd3; br = 1'b1; bt = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            settle($sformatf("md%0d", i));
            check($sformatf("md%0d hold", i), int'(hz0.EX_Hold), (i <= M0) ? 1 : 0);
            check($sformatf("md%0d exmem", i), int'(hz0.EX_MEM_Bubble), (i <= M0) ? 1 : 0);
            check($sformatf("md%0d busy", i), int'(hz0.Busy), (i >= 2) ? 1 : 0);
            if (i == 1) begin
                check("prio bubble", int'(hz0.ID_EX_Bubble), 0);
                check("prio flush", int'(hz0.IF_ID_Flush), 0);
            end
            if (i == 5) md = 1'b0;
            tick();
        end
        clear_inputs();
        settle("md_done");
        check("md busy_after", int'(hz0.Busy), 0);
        check("md count", int'(hz0.StallCycles), 5);

        // Asynchronous reset during BUSY, then a fresh count
        do_reset();
        md = 1'b1;
        settle("rstbusy"); tick();
        settle("rstbusy"); tick();
        Reset = 1'b1;
        settle("rstbusy_async");
        check("rstbusy busy", int'(hz0.Busy), 0);
        check("rstbusy count", int'(hz0.StallCycles), 0);
        check("rstbusy hold", int'(hz0.EX_Hold), 0);
        check("rstbusy pcw", int'(hz0.PCWrite), 1);
        tick();
        Reset = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            settle($sformatf("fresh%0d", i));
            check($sformatf("fresh%0d hold", i), int'(hz0.EX_Hold), (i <= M0) ? 1 : 0);
            if (i == 5) md = 1'b0;
            tick();
        end
        check("fresh count", int'(hz0.StallCycles), 4);

        // Counter saturation on the 2-bit instance
        do_reset();
        mrex = 1'b1; rdex = 5'd8; rs = 5'd8;
        repeat (5) begin
            settle("sat");
            tick();
        end
        clear_inputs();
        settle("sat_end");
        check("sat count_u1", int'(hz1.StallCycles), 3);
        check("sat count_u0", int'(hz0.StallCycles), 5);
        tick();

        // Randomised traffic against the model
        for (int n = 0; n < 600; n++) begin
            Reset = ($urandom_range(0, 59) == 0);
            rs    = 5'($urandom_range(0, 3));
            rt    = 5'($urandom_range(0, 3));
            rdex  = 5'($urandom_range(0, 3));
            rdmem = 5'($urandom_range(0, 3));
            urt   = 1'($urandom_range(0, 1));
            br    = 1'($urandom_range(0, 1));
            bt    = 1'($urandom_range(0, 1));
            rwex  = 1'($urandom_range(0, 1));
            mrex  = 1'($urandom_range(0, 1));
            mrmem = 1'($urandom_range(0, 1));
            md    = ($urandom_range(0, 5) == 0);
            settle($sformatf("rnd%0d", n));
            tick();
        end
        Reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
